// File: rtl/mem_stream_pkg.sv
// Shared types for the sequential-memory streaming blocks (reader now, writer later).
package mem_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/seq_mem_d1_reader_if.sv
// Memory-side and stream-side signals of the sequential memory reader.
interface seq_mem_d1_reader_if #(
   parameter int WIDTH    = 32,
   parameter int IDX_SIZE = 4
);
   logic [IDX_SIZE-1:0] mem_addr0;
   logic                mem_read_en;
   logic                mem_write_en;
   logic [WIDTH-1:0]    mem_in;
   logic [WIDTH-1:0]    mem_out;
   logic                mem_read_done;
   logic [WIDTH-1:0]    out_data;
   logic                out_valid;
   logic                out_ready;

   modport master (
      output mem_addr0, mem_read_en, mem_write_en, mem_in,
      input  mem_out, mem_read_done,
      output out_data, out_valid,
      input  out_ready
   );

   modport slave (
      input  mem_addr0, mem_read_en, mem_write_en, mem_in,
      output mem_out, mem_read_done,
      input  out_data, out_valid,
      output out_ready
   );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO; head is a flop so dout is glitch-free and resets to 0.
module stream_fifo2
   import mem_stream_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic [FIFO_CNT_W-1:0] count,
   output logic                  full,
   output logic                  empty
);
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             pop_ok;

   assign pop_ok = pop && (count != '0);
   assign empty  = (count == '0);
   assign full   = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign dout   = head;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (push && !pop_ok && !full) begin
            if (count == '0) head <= din;
            else             tail <= din;
            count <= count + 1'b1;
         end else if (!push && pop_ok) begin
            head  <= tail;
            count <= count - 1'b1;
         end else if (push && pop_ok) begin
            // count unchanged; at count 2 the tail moves up behind the new word
            if (count == FIFO_CNT_W'(1)) begin
               head <= din;
            end else begin
               head <= tail;
               tail <= din;
            end
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

endmodule

// File: rtl/seq_mem_d1_reader.sv
// Reads len consecutive words from a one-cycle sequential memory and streams them out.
module seq_mem_d1_reader
   import mem_stream_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SIZE      = 16,
   parameter int IDX_SIZE  = 4,
   parameter int LEN_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [IDX_SIZE-1:0]  base,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 done,
   output logic                 busy,
   seq_mem_d1_reader_if.master  bus
);
   rd_state_e state, state_nxt;

   logic [IDX_SIZE-1:0]   cur_addr;
   logic [IDX_SIZE-1:0]   addr_hold;
   logic [IDX_SIZE-1:0]   addr_inc;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  issued;
   logic [LEN_WIDTH-1:0]  popped;
   logic [LEN_WIDTH-1:0]  popped_nxt;
   logic                  inflight;
   logic                  rst_q;
   logic                  issue;
   logic                  credit_ok;
   logic                  push;
   logic                  pop;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [WIDTH-1:0]      fifo_head;

   // Words already owed to the FIFO (buffered + one in flight) must stay below 2 after this cycle's pop.
   assign credit_ok  = (3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop));
   assign pop        = !fifo_empty && bus.out_ready;
   // A read_done landing right after reset belongs to the abandoned transfer.
   assign push       = bus.mem_read_done && !rst_q;
   assign popped_nxt = popped + LEN_WIDTH'(pop);
   assign addr_inc   = (cur_addr == IDX_SIZE'(SIZE - 1)) ? '0 : cur_addr + 1'b1;

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (go) state_nxt = (len == '0) ? DONE : RUN;
         end
         RUN: begin
            issue = credit_ok;
            if (issue && (issued + LEN_WIDTH'(1) == len_q)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (popped_nxt == len_q) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         addr_hold <= '0;
         len_q     <= '0;
         issued    <= '0;
         popped    <= '0;
         inflight  <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= issue;
         if (state == IDLE && go) begin
            cur_addr <= base;
            len_q    <= len;
            issued   <= '0;
            popped   <= '0;
         end else begin
            if (issue) begin
               cur_addr  <= addr_inc;
               addr_hold <= cur_addr;
               issued    <= issued + LEN_WIDTH'(1);
            end
            if (pop) popped <= popped_nxt;
         end
      end
   end

   always_ff @(posedge clk) rst_q <= reset;

   stream_fifo2 #(.WIDTH(WIDTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (bus.mem_out),
      .pop   (pop),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.mem_read_en  = issue;
   assign bus.mem_addr0    = issue ? cur_addr : addr_hold;
   assign bus.mem_write_en = 1'b0;
   assign bus.mem_in       = '0;
   assign bus.out_valid    = !fifo_empty;
   assign bus.out_data     = fifo_head;
   assign done             = (state == DONE);
   assign busy             = (state != IDLE);

   a_credit: assert property (@(posedge clk) disable iff (reset) !(issue && fifo_full && !pop));

endmodule

// File: tb/tb_seq_mem_d1_reader.sv
// Randomised bench: a 16-word and a 10-word reader against a queue-based stream model.
module tb_seq_mem_d1_reader;
   logic        clk = 1'b0;
   logic        reset, go, rdy;
   logic [3:0]  base;
   logic [4:0]  len;
   logic        go16, go10, done16, done10, busy16, busy10;
   int          sel;
   int          total = 0;
   int          bad = 0;
   logic [31:0] m16 [16];
   logic [31:0] m10 [10];

   always #5 clk = ~clk;

   seq_mem_d1_reader_if #(.WIDTH(32), .IDX_SIZE(4)) b16 ();
   seq_mem_d1_reader_if #(.WIDTH(32), .IDX_SIZE(4)) b10 ();

   assign go16 = go & (sel == 0);
   assign go10 = go & (sel == 1);
   assign b16.out_ready = rdy;
   assign b10.out_ready = rdy;

   seq_mem_d1_reader #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4), .LEN_WIDTH(5)) u16 (
      .clk(clk), .reset(reset), .go(go16), .base(base), .len(len),
      .done(done16), .busy(busy16), .bus(b16.master));
   seq_mem_d1_reader #(.WIDTH(32), .SIZE(10), .IDX_SIZE(4), .LEN_WIDTH(5)) u10 (
      .clk(clk), .reset(reset), .go(go10), .base(base), .len(len),
      .done(done10), .busy(busy10), .bus(b10.master));

   // one-cycle sequential memories
   always @(posedge clk) begin
      b16.mem_read_done <= (b16.mem_read_en === 1'b1);
      if (b16.mem_read_en === 1'b1) b16.mem_out <= m16[b16.mem_addr0];
      b10.mem_read_done <= (b10.mem_read_en === 1'b1);
      if (b10.mem_read_en === 1'b1) b10.mem_out <= (b10.mem_addr0 < 4'd10) ? m10[b10.mem_addr0] : 32'hxxxx_xxxx;
   end

   logic        s_en, s_valid, s_done, s_busy, s_wen;
   logic [3:0]  s_addr;
   logic [31:0] s_data, s_min;
   assign s_en    = (sel == 1) ? b10.mem_read_en  : b16.mem_read_en;
   assign s_valid = (sel == 1) ? b10.out_valid    : b16.out_valid;
   assign s_done  = (sel == 1) ? done10           : done16;
   assign s_busy  = (sel == 1) ? busy10           : busy16;
   assign s_wen   = (sel == 1) ? b10.mem_write_en : b16.mem_write_en;
   assign s_addr  = (sel == 1) ? b10.mem_addr0    : b16.mem_addr0;
   assign s_data  = (sel == 1) ? b10.out_data     : b16.out_data;
   assign s_min   = (sel == 1) ? b10.mem_in       : b16.mem_in;

   function automatic logic ready_for(input int mode, input int c);
      int pat[6] = '{1, 0, 0, 1, 0, 1};
      case (mode)
         0:       return 1'b1;
         1:       return pat[c % 6] != 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 16; i++) m16[i] = $urandom;
      for (int i = 0; i < 10; i++) m10[i] = $urandom;
   endtask

   // One transfer; the model is simply the list of words base..base+len-1 mod SIZE.
   task automatic run_xfer(input int s, input int b, input int l, input int mode, input bit stray);
      int sz, ndone, done_cyc, last_hs, first_v, outst, nread;
      bit fin;
      logic [31:0] exp_d[$];
      logic [31:0] got_d[$];
      int exp_a[$];
      int got_a[$];
      sel = s;
      sz  = (s == 1) ? 10 : 16;
      for (int i = 0; i < l; i++) begin
         exp_a.push_back((b + i) % sz);
         exp_d.push_back((s == 1) ? m10[(b + i) % sz] : m16[(b + i) % sz]);
      end
      ndone = 0; done_cyc = -1; last_hs = -1; first_v = -1; outst = 0; nread = 0; fin = 1'b0;
      @(negedge clk);
      go = 1'b1; base = 4'(b); len = 5'(l); rdy = ready_for(mode, 0);
      for (int c = 1; c <= 400 && !fin; c++) begin
         @(negedge clk);
         go = 1'b0;
         if (stray && ndone == 0 && (c % 3 == 2)) begin
            go = 1'b1; base = 4'($urandom_range(0, sz - 1)); len = 5'($urandom_range(1, 16));
         end
         rdy = ready_for(mode, c);
         #1;
         total++;
         if (s_wen !== 1'b0 || s_min !== 32'd0) begin
            bad++; $display("FAIL write_tie: write_en=%b in=%h, required 0/0", s_wen, s_min);
         end
         if (s_en) begin
            total++;
            if (outst - int'(s_valid && rdy) >= 2) begin
               bad++; $display("FAIL credit: read issued with %0d owed words, required < 2", outst - int'(s_valid && rdy));
            end
            got_a.push_back(int'(s_addr));
            nread++;
         end
         if (s_valid && rdy) begin got_d.push_back(s_data); last_hs = c; outst--; end
         if (s_en) outst++;
         if (s_valid && first_v < 0) first_v = c;
         if (s_done) begin ndone++; done_cyc = c; end
         if (done_cyc >= 0 && c >= done_cyc + 1) fin = 1'b1;
      end
      total++;
      if (!fin) begin bad++; $display("FAIL timeout: transfer base=%0d len=%0d never finished", b, l); end
      total++;
      if (got_d.size() != l) begin
         bad++; $display("FAIL stream_len: got %0d words, required %0d", got_d.size(), l);
      end
      for (int i = 0; i < l && i < got_d.size(); i++) begin
         total++;
         if (got_d[i] !== exp_d[i]) begin
            bad++; $display("FAIL data[%0d]: got %h, required %h", i, got_d[i], exp_d[i]);
         end
      end
      total++;
      if (nread != l) begin bad++; $display("FAIL read_count: got %0d, required %0d", nread, l); end
      for (int i = 0; i < l && i < got_a.size(); i++) begin
         total++;
         if (got_a[i] != exp_a[i]) begin
            bad++; $display("FAIL addr[%0d]: got %0d, required %0d", i, got_a[i], exp_a[i]);
         end
      end
      total++;
      if (ndone != 1) begin bad++; $display("FAIL done_count: got %0d, required 1", ndone); end
      total++;
      if (done_cyc != ((l == 0) ? 1 : last_hs + 1)) begin
         bad++; $display("FAIL done_cycle: got %0d, required %0d", done_cyc, (l == 0) ? 1 : last_hs + 1);
      end
      if (mode == 0 && l > 0) begin
         total++;
         if (first_v != 3) begin bad++; $display("FAIL first_valid: got cycle %0d, required 3", first_v); end
         total++;
         if (done_cyc != l + 3) begin bad++; $display("FAIL throughput: done at %0d, required %0d", done_cyc, l + 3); end
      end
      total++;
      if (s_busy !== 1'b0) begin bad++; $display("FAIL busy_after: got %b, required 0", s_busy); end
   endtask

   task automatic test_reset();
      reset = 1'b1; go = 1'b0; rdy = 1'b0; base = '0; len = '0; sel = 0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         total += 6;
         if (s_done !== 1'b0)   begin bad++; $display("FAIL rst_done%0d: got %b, required 0", s, s_done); end
         if (s_busy !== 1'b0)   begin bad++; $display("FAIL rst_busy%0d: got %b, required 0", s, s_busy); end
         if (s_en !== 1'b0)     begin bad++; $display("FAIL rst_read_en%0d: got %b, required 0", s, s_en); end
         if (s_addr !== 4'd0)   begin bad++; $display("FAIL rst_addr%0d: got %0d, required 0", s, s_addr); end
         if (s_valid !== 1'b0)  begin bad++; $display("FAIL rst_valid%0d: got %b, required 0", s, s_valid); end
         if (s_data !== 32'd0)  begin bad++; $display("FAIL rst_data%0d: got %h, required 0", s, s_data); end
      end
      sel = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 16; i++) m16[i] = 32'(i * 3);
      run_xfer(0, 2, 4, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      run_xfer(0, 2, 4, 1, 1'b0);
      fill_random();
      run_xfer(0, 9, 11, 1, 1'b0);
      run_xfer(0, $urandom_range(0, 15), $urandom_range(1, 16), 2, 1'b0);
   endtask

   task automatic test_wrap();
      fill_random();
      run_xfer(1, 8, 4, 0, 1'b0);
      run_xfer(1, 8, 4, 2, 1'b0);
      run_xfer(0, 14, 5, 1, 1'b0);
   endtask

   task automatic test_boundary();
      run_xfer(0, 5, 0, 0, 1'b0);
      run_xfer(0, 0, 16, 0, 1'b0);
      run_xfer(1, 3, 10, 2, 1'b0);
      run_xfer(0, 7, 16, 2, 1'b0);
   endtask

   task automatic test_ignored_go();
      fill_random();
      run_xfer(0, 4, 6, 1, 1'b1);
      run_xfer(1, 6, 7, 0, 1'b1);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         int s;
         s = $urandom_range(0, 1);
         fill_random();
         run_xfer(s, $urandom_range(0, (s == 1) ? 9 : 15), $urandom_range(0, (s == 1) ? 10 : 16), 2, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      fill_random();
      sel = 0;
      // reset in DRAIN with both entries full
      @(negedge clk); go = 1'b1; base = 4'd3; len = 5'd2; rdy = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); go = 1'b0;
         if (c == 4) begin
            #1;
            total += 2;
            if (s_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid: got %b, required 1", s_valid); end
            if (s_busy !== 1'b1)  begin bad++; $display("FAIL pre_rst_busy: got %b, required 1", s_busy); end
            reset = 1'b1;
         end
      end
      @(negedge clk); reset = 1'b0; rdy = 1'b1;
      #1;
      total += 2;
      if (s_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b, required 0", s_valid); end
      if (s_busy !== 1'b0)  begin bad++; $display("FAIL post_rst_busy: got %b, required 0", s_busy); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         total++;
         if (s_done !== 1'b0 || s_valid !== 1'b0) begin
            bad++; $display("FAIL abandoned_a: done=%b valid=%b, required 0/0", s_done, s_valid);
         end
      end
      // reset while a read is being issued; its read_done arrives after reset
      @(negedge clk); go = 1'b1; base = 4'd10; len = 5'd4; rdy = 1'b1;
      @(negedge clk); go = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         total++;
         if (s_done !== 1'b0 || s_valid !== 1'b0 || s_en !== 1'b0) begin
            bad++; $display("FAIL abandoned_b: done=%b valid=%b read_en=%b, required 0/0/0", s_done, s_valid, s_en);
         end
         @(negedge clk);
      end
      run_xfer(0, $urandom_range(0, 15), 1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_wrap();
      test_boundary();
      test_ignored_go();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mem_d1_reader.md
Name: seq_mem_d1_reader

Overview:
- Initiator for the one-cycle sequential memory interface (addr0/read_en/out/read_done/write_en/in/write_done).
- On go, the block reads len consecutive words starting at base.
- It streams the words out on a ready/valid port, in address order, with full backpressure.
- It sits between a seq_mem_d1 instance and a streaming consumer; a done pulse reports completion to the control schedule.

Parameters:
- WIDTH, 32, data word width; matches the memory WIDTH.
- SIZE, 16, number of memory words; sets the address wrap point.
- IDX_SIZE, 4, memory address width.
- LEN_WIDTH, 5, width of the len input; must be at least IDX_SIZE+1 so that len=SIZE is expressible.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- go  in  1  start request; level, sampled only in IDLE
- base  in  IDX_SIZE  first address; latched on accepted go
- len  in  LEN_WIDTH  word count; latched on accepted go
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- mem_addr0  out  IDX_SIZE  memory address
- mem_read_en  out  1  memory read strobe
- mem_write_en  out  1  constant 0
- mem_in  out  WIDTH  constant 0
- mem_out  in  WIDTH  memory read data
- mem_read_done  in  1  memory read-data-valid
- out_data  out  WIDTH  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. Reset clears FSM, counters and FIFO.
- Reset values: done=0, busy=0, mem_read_en=0, mem_addr0=0, out_valid=0, out_data=0.
- Reset mid-operation abandons the transfer. A read_done returning in the cycle after reset is ignored, and no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on go, latch base/len and clear issued/popped counters. Move to RUN, or to DONE if len==0.
  - RUN: issues reads. Moves to DRAIN in the cycle the last read is issued.
  - DRAIN: waits until the popped count reaches len, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- go in any state other than IDLE is ignored.
- Read issue:
  - mem_read_en is combinational from state and credit. It is never asserted outside RUN.
  - mem_addr0 = current address whenever mem_read_en=1; otherwise it holds its last value.
  - Credit rule: issue when fifo_count + inflight - pop < 2, where pop = out_valid & out_ready in the same cycle, and inflight = 1 if a read was issued the previous cycle.
  - With out_ready held high, this rule sustains 1 word/cycle.
- Addressing: address starts at base and increments by 1 per issued read. After SIZE-1 it wraps to 0, which matters when SIZE is not a power of 2. The wrap is mod SIZE, not mod 2^IDX_SIZE.
- Capture: when mem_read_done=1, push mem_out into a 2-entry FIFO at that clock edge. mem_out is not sampled on any other cycle.
- FIFO:
  - out_valid = (count>0); out_data = head entry, registered.
  - Simultaneous push and pop is allowed at count 1 and at count 2; count is unchanged.
  - Overflow is impossible by the credit rule; a sim-only assertion flags a push at count 2 without a pop.
- Latency: go sampled at edge E0 → first mem_read_en in cycle 1 → mem_read_done in cycle 2 → out_valid in cycle 3.
- Completion: done asserts the cycle after the final stream handshake.
- Counters: issued and popped are LEN_WIDTH bits. len=SIZE reads every word exactly once.
- Writes: the block never writes. mem_write_en and mem_in are tied 0, so the memory's simultaneous read/write check never fires.

Decomposition:
- Shared package (mem_stream_pkg): the FSM state enum {IDLE,RUN,DRAIN,DONE} and the FIFO depth constant FIFO_DEPTH=2.
- One sub-module: stream_fifo2, a WIDTH-parameterised 2-entry registered FIFO with push/pop/count/full/empty. It is reusable by the future writer-side block.

Test Plan:
- Streaming: mem[i]=i*3, base=2, len=4, out_ready=1 → out_valid cycles 3..6 with out_data 6,9,12,15; done pulse at cycle 7; mem_read_en exactly 4 cycles.
- Backpressure: same setup with out_ready toggling 1,0,0,1,0,1,... → same 4 values in order, none dropped or duplicated; mem_read_en never asserted while fifo_count+inflight-pop ≥2.
- Wrap: SIZE=10, IDX_SIZE=4, base=8, len=4 → mem_addr0 sequence 8,9,0,1; never 10..15.
- Boundary lengths: len=0 → done one cycle after go with no mem_read_en; len=SIZE, base=0 → all 16 words streamed once.
- Reset mid-operation and ignored go: reset asserted in DRAIN with 2 words buffered → next cycle out_valid=0, busy=0, and no done; a following go with len=1 completes normally. Pulsing go while busy changes nothing in the stream.
